// File: rtl/comparator_sweep_driver.sv
// -----------------------------------------------------------------------------
// comparator_sweep_driver
//
// Self-test stimulus generator for an N-bit unsigned magnitude comparator.
// A start pulse launches a walking-bit sweep of 4N+3 vectors. Each vector is
// held on A/B for HOLD cycles. The comparator's EQ/LT are sampled on the last
// cycle of the hold window and checked against the expectation that was
// registered together with the vector. Mismatches are counted (saturating),
// and the index of the first failing vector is recorded.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   one-cycle sweep request, honoured only when idle
//   A, B        out  comparator operands (registered)
//   EQ, LT      in   comparator results (A==B, A<B unsigned)
//   busy        out  sweep in progress
//   done        out  one-cycle pulse after the last vector is checked
//   pass        out  last completed sweep had zero mismatches
//   err_count   out  mismatch count of the current/last sweep, saturating
//   first_fail  out  index of the first mismatching vector, 0 when none
// -----------------------------------------------------------------------------
module comparator_sweep_driver #(
    parameter int N    = 8,
    parameter int HOLD = 4,
    parameter int IW   = $clog2(4 * N + 4)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [N-1:0]  A,
    output logic [N-1:0]  B,
    input  logic          EQ,
    input  logic          LT,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [IW-1:0] err_count,
    output logic [IW-1:0] first_fail
);

    localparam int            HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IW-1:0] LAST_K  = IW'(4 * N + 2);
    localparam logic [HW-1:0] H_LAST  = HW'(HOLD - 1);
    localparam logic [IW-1:0] ERR_MAX = '1;
    localparam logic [N-1:0]  ONE     = N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    // Operands plus the comparator response they should produce.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         eq;
        logic         lt;
    } vec_t;

    localparam vec_t IDLE_VEC = '{a: '1, b: '1, eq: 1'b1, lt: 1'b0};

    // Vector table: walking zero through ones on A, then walking one through
    // zeros on B, each "unequal" vector followed by an "equal" recovery vector.
    function automatic vec_t vec_of(input logic [IW-1:0] k);
        vec_t v;
        int   kk;
        int   i;
        int   m;
        kk = int'(k);
        v  = IDLE_VEC;
        if (kk == 0) begin
            v = IDLE_VEC;
        end else if (kk <= 2 * N) begin
            i = N - 1 - (kk - 1) / 2;
            if (kk % 2 == 1) begin
                v.a  = ~(ONE << i);
                v.eq = 1'b0;
                v.lt = 1'b1;
            end
        end else if (kk == 2 * N + 1) begin
            v.a  = '0;
            v.eq = 1'b0;
            v.lt = 1'b1;
        end else begin
            v.a = '0;
            v.b = '0;
            if (kk > 2 * N + 2) begin
                m = kk - 2 * N - 3;
                i = N - 1 - m / 2;
                if (m % 2 == 0) begin
                    v.b  = ONE << i;
                    v.eq = 1'b0;
                    v.lt = 1'b1;
                end
            end
        end
        return v;
    endfunction

    state_e        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [HW-1:0] h_q, h_d;
    vec_t          vec_q, vec_d;
    logic [IW-1:0] err_q, err_d;
    logic [IW-1:0] ff_q, ff_d;
    logic          pass_q, pass_d;
    logic          mismatch;

    assign mismatch = (EQ != vec_q.eq) || (LT != vec_q.lt);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        h_d     = h_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    h_d     = '0;
                    vec_d   = vec_of('0);
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (h_q == H_LAST) begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + IW'(1);
                        if (err_q == '0)      ff_d  = k_q;
                    end
                    if (k_q == LAST_K) begin
                        // err_d already includes a mismatch on the final vector.
                        state_d = S_FIN;
                        vec_d   = IDLE_VEC;
                        pass_d  = (err_d == '0);
                    end else begin
                        k_d   = k_q + IW'(1);
                        h_d   = '0;
                        vec_d = vec_of(k_q + IW'(1));
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = IDLE_VEC;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            h_q     <= '0;
            vec_q   <= IDLE_VEC;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            h_q     <= h_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign A          = vec_q.a;
    assign B          = vec_q.b;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_FIN);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_comparator_sweep_driver
//
// Drives comparator_sweep_driver (N=8, HOLD=4) against a behavioural
// comparator with selectable faults: 0 ideal, 1 LT stuck at 0, 2 EQ stuck
// at 1, 3 bit 0 of B ignored (replaced by A[0]). All expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_comparator_sweep_driver;

    localparam int N    = 8;
    localparam int HOLD = 4;
    localparam int IW   = $clog2(4 * N + 4);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  A, B;
    logic          EQ, LT;
    logic          busy, done, pass;
    logic [IW-1:0] err_count, first_fail;

    logic [1:0]    mode;
    logic [N-1:0]  b_eff;

    int total = 0;
    int bad   = 0;

    comparator_sweep_driver #(.N(N), .HOLD(HOLD), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .EQ         (EQ),
        .LT         (LT),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Comparator under test, with fault injection.
    always_comb begin
        b_eff = (mode == 2'd3) ? {B[N-1:1], A[0]} : B;
        EQ    = (A == b_eff);
        LT    = (A < b_eff);
        if (mode == 2'd1) LT = 1'b0;
        if (mode == 2'd2) EQ = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spot vectors: index k, expected A, expected B.
    int           vk [7] = '{0, 1, 16, 17, 18, 19, 33};
    logic [N-1:0] va [7] = '{8'hFF, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [N-1:0] vb [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h01};

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the first IDLE cycle after FIN (cycle 142 counting from start).
    task automatic run_sweep(input logic [1:0] m, input bit repulse, input bit spot,
                             input int exp_err, input int exp_ff, input bit exp_pass);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = 0;
        bit pass_at_done = 1'b0;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cleared_err", err_count, 0);
        check("cleared_ff",  first_fail, 0);
        for (int cyc = 1; cyc <= 142; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                pass_at_done = pass;
                check("busy_in_fin", busy, 0);
            end
            if (spot) begin
                for (int j = 0; j < 7; j++) begin
                    if (cyc == vk[j] * HOLD + 1 || cyc == vk[j] * HOLD + HOLD) begin
                        check($sformatf("A_k%0d", vk[j]), A, va[j]);
                        check($sformatf("B_k%0d", vk[j]), B, vb[j]);
                    end
                end
            end
            start = repulse && (cyc == 21 || cyc == 141);
            if (cyc < 142) @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", busy_cnt, 140);
        check("done_count",  done_cnt, 1);
        check("done_cycle",  done_cyc, 141);
        check("pass_done",   pass_at_done, exp_pass);
        check("pass_held",   pass, exp_pass);
        check("err_count",   err_count, exp_err);
        check("first_fail",  first_fail, exp_ff);
        check("idle_A",      A, 8'hFF);
        check("idle_B",      B, 8'hFF);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err",  err_count, 0);
        check("rst_ff",   first_fail, 0);
        check("rst_A",    A, 8'hFF);
        check("rst_B",    B, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Back-to-back sweeps, each start issued in the cycle after FIN.
        run_sweep(2'd0, 1'b0, 1'b1, 0, 0, 1'b1);
        run_sweep(2'd1, 1'b0, 1'b0, 17, 1, 1'b0);
        run_sweep(2'd2, 1'b0, 1'b0, 17, 1, 1'b0);
        run_sweep(2'd3, 1'b0, 1'b0, 2, 15, 1'b0);
        run_sweep(2'd0, 1'b1, 1'b0, 0, 0, 1'b1);

        // Reset while vector 10 is on the bus, after five LT mismatches.
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (41) @(negedge clk);
        check("pre_rst_err",  err_count, 5);
        check("pre_rst_A",    A, 8'hFF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err",  err_count, 0);
        check("abort_ff",   first_fail, 0);
        check("abort_A",    A, 8'hFF);
        check("abort_B",    B, 8'hFF);
        dcnt = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("abort_quiet", dcnt, 0);
        run_sweep(2'd0, 1'b0, 1'b0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_sweep_driver.md
# comparator_sweep_driver

Self-checking stimulus generator for the parameterised magnitude comparator (inputs A, B; outputs EQ, LT). On a start pulse it drives the comparator's operand ports through a fixed walking-bit sweep, samples EQ/LT at the end of each hold window, checks them against internally computed expectations, and reports pass/fail, an error count and the first failing vector. It sits on the opposite side of the comparator interface, driving its operands and consuming its results, for on-board or emulation self-test.

## Interface
- N, 8: operand width; N >= 2.
- HOLD, 4: clock cycles each vector is held; HOLD >= 2.
- IW, $clog2(4N+4): width of vector index and error count.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run the sweep; ignored unless idle.
- A  out  N  comparator operand A.
- B  out  N  comparator operand B.
- EQ  in  1  comparator A==B result.
- LT  in  1  comparator A<B (unsigned) result.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last vector is checked.
- pass  out  1  high when the last completed sweep had zero mismatches.
- err_count  out  IW  mismatch count of the current/last sweep, saturating.
- first_fail  out  IW  index k of the first mismatching vector; 0 when none.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: A = B = all ones; busy = 0. start=1 -> RUN with k = 0, hold counter h = 0, err_count = 0, first_fail = 0, pass = 0.
- RUN: drives vector k, 4N+3 vectors total (k = 0 .. 4N+2); i(k) is the bit under test.
  - k=0: A=ones, B=ones; expect EQ=1, LT=0.
  - k=1..2N: i = N-1-(k-1)/2; odd k: A=ones with bit i cleared, B=ones, expect EQ=0 LT=1; even k: A=B=ones, expect EQ=1 LT=0.
  - k=2N+1: A=0, B=ones; expect EQ=0, LT=1.
  - k=2N+2: A=0, B=0; expect EQ=1, LT=0.
  - k=2N+3..4N+2: m = k-2N-3, i = N-1-m/2; m even: A=0, B has only bit i set, expect EQ=0 LT=1; m odd: A=B=0, expect EQ=1 LT=0.
- Check: on the cycle h == HOLD-1, compare EQ and LT with expectation; either bit wrong -> one mismatch. On mismatch, err_count += 1 unless at max (saturates at 2^IW-1); if err_count == 0 before increment, first_fail <= k.
- Advance: h == HOLD-1 and k < 4N+2 -> k+1, h = 0; h == HOLD-1 and k == 4N+2 -> FIN.
- FIN (one cycle): done = 1, pass = (err_count == 0), A = B = all ones, then -> IDLE.
- err_count, first_fail, pass hold their values in IDLE until the next accepted start.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, A = B = all ones, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, k = 0, h = 0. Reset mid-sweep aborts immediately; no done pulse.
- start sampled at edge T in IDLE: from T+1, busy = 1 and vector 0 is on A/B.
- A/B change only at vector boundaries, registered; each vector is stable for exactly HOLD cycles.
- EQ/LT are treated as combinational from A/B and sampled HOLD-1 cycles after the vector is applied.
- Sweep length: busy high for (4N+3)*HOLD cycles; done pulses the cycle after busy falls (FIN), and in FIN busy = 0.
- start while busy or in FIN: ignored, no effect on k, h or counters.
- start in the cycle after FIN (IDLE): accepted normally; back-to-back sweeps allowed.
- Mismatch on the final vector is counted before done/pass are asserted.

## Test plan
- N=8, HOLD=4, ideal comparator model; pulse start -> 35 vectors, busy high 140 cycles, done pulse one cycle later, pass=1, err_count=0, first_fail=0.
- Comparator with LT stuck at 0 -> err_count=17 (all LT=1 vectors: k=1,3,...,15,17,19,...,33), first_fail=1, pass=0.
- Comparator with EQ stuck at 1 -> err_count=17, first_fail=1, pass=0; comparator with bit 0 of B ignored -> mismatches only at k=15 and k=33, err_count=2, first_fail=15.
- start re-pulsed at vector 5 and during FIN -> ignored; single done pulse at cycle 141 after the original start; a start one cycle after FIN launches a new sweep and clears err_count.
- rst_n low for one edge while k=10 -> next cycle busy=0, A=B=8'hFF, err_count=0, no done; a subsequent start runs a full clean sweep with pass=1.
